regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (WE / WriteReg / WriteData) between two writeback requesters. Typical requesters are ALU writeback and load/memory writeback. Each requester uses a valid/ready handshake; the arbiter grants at most one per cycle and registers the winning write onto the port. The block sits between the writeback stages and Registers_Block, and drives that block's write inputs directly.

---
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port; registered write, saturating conflict counter.
// Optional same-cycle read forwarding when REGFILE_WR_BYPASS_EN is defined.
module regfile_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              WE,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  conflict_cnt
`ifdef REGFILE_WR_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] wdata;
    } wrReq_t;

    wrReq_t [1:0] reqs;
    wrReq_t       winner;
    logic   [1:0] valids;
    logic   [1:0] grant;
    logic         lastGrant;
    logic         accept;
    logic         bothValid;

    assign reqs[0]   = {req0_reg, req0_data};
    assign reqs[1]   = {req1_reg, req1_data};
    assign valids    = {req1_valid, req0_valid};
    assign bothValid = &valids;

    // On a conflict, the requester that did not win last time goes next;
    // fixed-priority mode ignores lastGrant and always favours req0.
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (bothValid) begin
                if (ARB_MODE == 1 || lastGrant) grant = 2'b01;
                else                            grant = 2'b10;
            end else begin
                grant = valids;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign winner     = grant[1] ? reqs[1] : reqs[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            WE           <= 1'b0;
            WriteReg     <= '0;
            WriteData    <= '0;
            lastGrant    <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            // Writes to $zero complete the handshake but never assert WE.
            WE <= accept && (winner.wreg != '0);
            if (accept) begin
                WriteReg  <= winner.wreg;
                WriteData <= winner.wdata;
            end
            if (accept && ARB_MODE == 0) lastGrant <= grant[1];
            if (bothValid && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    logic [1:0][ADDR_W-1:0] rdAddr;
    logic [1:0][DATA_W-1:0] rfData;
    logic [1:0][DATA_W-1:0] fwdData;

    assign rdAddr    = {rd_addr2, rd_addr1};
    assign rfData    = {rf_data2, rf_data1};
    assign fwd_data1 = fwdData[0];
    assign fwd_data2 = fwdData[1];

    for (genvar k = 0; k < 2; k++) begin : gFwd
        assign fwdData[k] = (WE && WriteReg == rdAddr[k] && rdAddr[k] != '0)
                            ? WriteData : rfData[k];
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + random bench for regfile_write_arbiter: instance 0 round-robin, instance 1 fixed priority,
// both checked each cycle against a transaction-level reference model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0 [2];
    logic        v1 [2];
    logic [4:0]  r0 [2];
    logic [4:0]  r1 [2];
    logic [31:0] d0 [2];
    logic [31:0] d1 [2];
    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        we [2];
    logic [4:0]  wreg [2];
    logic [31:0] wdata [2];
    logic [3:0]  cnt [2];
`ifdef REGFILE_WR_BYPASS_EN
    logic [4:0]  ra1 [2];
    logic [4:0]  ra2 [2];
    logic [31:0] rf1 [2];
    logic [31:0] rf2 [2];
    logic [31:0] fw1 [2];
    logic [31:0] fw2 [2];
`endif

    int nCmp  = 0;
    int nFail = 0;

    // reference model state
    int          mLast [2];
    logic        mWE   [2];
    logic [4:0]  mReg  [2];
    logic [31:0] mData [2];
    int          mCnt  [2];
    int          win   [2];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .ARB_MODE(0), .CNT_W(4)) dutRr (
        .clk(clk), .rst(rst),
        .req0_valid(v0[0]), .req0_reg(r0[0]), .req0_data(d0[0]), .req0_ready(rdy0[0]),
        .req1_valid(v1[0]), .req1_reg(r1[0]), .req1_data(d1[0]), .req1_ready(rdy1[0]),
        .WE(we[0]), .WriteReg(wreg[0]), .WriteData(wdata[0]), .conflict_cnt(cnt[0])
`ifdef REGFILE_WR_BYPASS_EN
        , .rd_addr1(ra1[0]), .rd_addr2(ra2[0]), .rf_data1(rf1[0]), .rf_data2(rf2[0]),
        .fwd_data1(fw1[0]), .fwd_data2(fw2[0])
`endif
    );

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .ARB_MODE(1), .CNT_W(4)) dutFp (
        .clk(clk), .rst(rst),
        .req0_valid(v0[1]), .req0_reg(r0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
        .req1_valid(v1[1]), .req1_reg(r1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
        .WE(we[1]), .WriteReg(wreg[1]), .WriteData(wdata[1]), .conflict_cnt(cnt[1])
`ifdef REGFILE_WR_BYPASS_EN
        , .rd_addr1(ra1[1]), .rd_addr2(ra2[1]), .rf_data1(rf1[1]), .rf_data2(rf2[1]),
        .fwd_data1(fw1[1]), .fwd_data2(fw2[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Who the spec says should win this cycle for instance m (-1 = nobody).
    function automatic int pick(int m);
        if (rst) return -1;
        if (v0[m] && v1[m]) return (m == 1) ? 0 : 1 - mLast[m];
        if (v0[m]) return 0;
        if (v1[m]) return 1;
        return -1;
    endfunction

    // Inputs are set just after a rising edge; check readies mid-cycle, then the port after the edge.
    task automatic doCycle();
        #2;
        for (int m = 0; m < 2; m++) begin
            win[m] = pick(m);
            chk($sformatf("m%0d.ready0", m), {31'b0, rdy0[m]}, {31'b0, win[m] == 0});
            chk($sformatf("m%0d.ready1", m), {31'b0, rdy1[m]}, {31'b0, win[m] == 1});
`ifdef REGFILE_WR_BYPASS_EN
            if (!rst) begin
                chk($sformatf("m%0d.fwd1", m), fw1[m],
                    (mWE[m] && mReg[m] == ra1[m] && ra1[m] != 0) ? mData[m] : rf1[m]);
                chk($sformatf("m%0d.fwd2", m), fw2[m],
                    (mWE[m] && mReg[m] == ra2[m] && ra2[m] != 0) ? mData[m] : rf2[m]);
            end
`endif
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mWE[m] = 0; mReg[m] = 0; mData[m] = 0; mCnt[m] = 0; mLast[m] = 1;
            end else begin
                if (v0[m] && v1[m] && mCnt[m] < 15) mCnt[m]++;
                mWE[m] = 0;
                if (win[m] >= 0) begin
                    mReg[m]  = (win[m] == 0) ? r0[m] : r1[m];
                    mData[m] = (win[m] == 0) ? d0[m] : d1[m];
                    mWE[m]   = (mReg[m] != 0);
                    if (m == 0) mLast[m] = win[m];
                end
            end
            chk($sformatf("m%0d.WE", m), {31'b0, we[m]}, {31'b0, mWE[m]});
            chk($sformatf("m%0d.WriteReg", m), {27'b0, wreg[m]}, {27'b0, mReg[m]});
            chk($sformatf("m%0d.WriteData", m), wdata[m], mData[m]);
            chk($sformatf("m%0d.conflict_cnt", m), {28'b0, cnt[m]}, mCnt[m]);
        end
    endtask

    // A granted requester drops valid; others keep holding.
    task automatic retire();
        for (int m = 0; m < 2; m++) begin
            if (win[m] == 0) v0[m] = 0;
            if (win[m] == 1) v1[m] = 0;
        end
    endtask

    initial begin
        rst = 1;
        for (int m = 0; m < 2; m++) begin
            v0[m] = 0; v1[m] = 0; r0[m] = 0; r1[m] = 0; d0[m] = 0; d1[m] = 0;
            mLast[m] = 1; mWE[m] = 0; mReg[m] = 0; mData[m] = 0; mCnt[m] = 0; win[m] = -1;
`ifdef REGFILE_WR_BYPASS_EN
            ra1[m] = 0; ra2[m] = 0; rf1[m] = 0; rf2[m] = 0;
`endif
        end
        doCycle();
        doCycle();
        rst = 0;

        // single write from req0
        v0[0] = 1; r0[0] = 5'd1; d0[0] = 32'hA5A5A5A5;
        doCycle();
        chk("plan.we_after_accept", {31'b0, we[0]}, 32'd1);
        chk("plan.wdata_after_accept", wdata[0], 32'hA5A5A5A5);
        retire();
        doCycle();

        // round-robin conflict run from a fresh reset
        rst = 1; doCycle(); rst = 0;
        v0[0] = 1; r0[0] = 5'd2; d0[0] = 32'h5A5A5A5A;
        v1[0] = 1; r1[0] = 5'd3; d1[0] = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            doCycle();
            chk("plan.we_streak", {31'b0, we[0]}, 32'd1);
            chk("plan.alternate", {27'b0, wreg[0]}, (i % 2 == 0) ? 32'd2 : 32'd3);
        end
        chk("plan.cnt4", {28'b0, cnt[0]}, 32'd4);
        v0[0] = 0; v1[0] = 0;
        doCycle();

        // fixed priority: req1 starves while req0 holds valid
        v0[1] = 1; r0[1] = 5'd4; d0[1] = 32'h0BADBEEF;
        v1[1] = 1; r1[1] = 5'd5; d1[1] = 32'h00C0FFEE;
        for (int i = 0; i < 3; i++) begin
            doCycle();
            chk("plan.fp_starve", {31'b0, rdy1[1]}, 32'd0);
        end
        v0[1] = 0;
        doCycle();
        retire();
        doCycle();
        chk("plan.fp_req1_write", {27'b0, wreg[1]}, 32'd5);

        // write to $zero: handshake completes, WE stays low
        v1[0] = 1; r1[0] = 5'd0; d1[0] = 32'hFFFFFFFF;
        doCycle();
        chk("plan.zero_we", {31'b0, we[0]}, 32'd0);
        retire();
        doCycle();

        // reset right after an accept
        v0[0] = 1; r0[0] = 5'd7; d0[0] = 32'h77777777;
        doCycle();
        retire();
        rst = 1;
        doCycle();
        rst = 0;
        chk("plan.rst_we", {31'b0, we[0]}, 32'd0);
        chk("plan.rst_cnt", {28'b0, cnt[0]}, 32'd0);
        v0[0] = 1; r0[0] = 5'd8; d0[0] = 32'h88888888;
        v1[0] = 1; r1[0] = 5'd9; d1[0] = 32'h99999999;
        doCycle();
        chk("plan.post_rst_grant", {27'b0, wreg[0]}, 32'd8);
        retire();

        // random traffic honouring the hold-until-ready rule, occasional resets, counter saturation
        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!v0[m] && $urandom_range(0, 2) != 0) begin
                    v0[m] = 1; r0[m] = 5'($urandom_range(0, 7)); d0[m] = $urandom;
                end
                if (!v1[m] && $urandom_range(0, 2) != 0) begin
                    v1[m] = 1; r1[m] = 5'($urandom_range(0, 7)); d1[m] = $urandom;
                end
`ifdef REGFILE_WR_BYPASS_EN
                ra1[m] = 5'($urandom_range(0, 7)); ra2[m] = 5'($urandom_range(0, 7));
                rf1[m] = $urandom; rf2[m] = $urandom;
`endif
            end
            rst = ($urandom_range(0, 79) == 0);
            doCycle();
            retire();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
